jammer_conv_ctrl: RTL and testbench
===================================

JAMMER_CONV_CTRL -- requirements
Module: jammer_conv_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, sample/coefficient width.
REQ-002 Parameter NUM, default 8, coefficient count per load.
REQ-003 Parameter LEN_W, default 12, frame_len width.
REQ-004 Parameter CONV_LAT, default 2, cycles from conv_sig_vld to valid conv_sig_out.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous reset, active-high.
REQ-007 start  in  1  one-cycle job request.
REQ-008 frame_len  in  LEN_W  samples per frame, sampled on accepted start.
REQ-009 coe_reload  in  1  1 = load NUM coefficients before streaming, sampled on accepted start.
REQ-010 abort  in  1  synchronous job cancel.
REQ-011 coe_data / coe_valid / coe_ready  in / in / out  WIDTH / 1 / 1  coefficient source handshake.
REQ-012 smp_data / smp_valid / smp_ready  in / in / out  WIDTH / 1 / 1  sample source handshake.
REQ-013 conv_coe, conv_coes_vld, conv_sig_in, conv_sig_vld, conv_last_sig  out  WIDTH,1,WIDTH,1,1  drive convolver.
REQ-014 conv_sig_out  in  2*WIDTH  convolver result.
REQ-015 res_data / res_valid / res_last  out  2*WIDTH / 1 / 1  result stream; sink always ready.
REQ-016 busy / done / err  out  1 each  status; done and err are one-cycle pulses.

Function
REQ-017 FSM states IDLE, LOAD, STREAM, DRAIN, DONE; busy SHALL be 1 in every state except IDLE.
REQ-018 IDLE: start with frame_len==0, or with coe_reload==0 and coef_loaded==0, SHALL pulse err next cycle and remain IDLE.
REQ-019 IDLE: valid start SHALL go to LOAD if coe_reload==1, else STREAM; start while busy SHALL be ignored.
REQ-020 LOAD: coe_ready=1; each coe handshake SHALL register conv_coe<=coe_data, conv_coes_vld=1 the following cycle; otherwise conv_coes_vld=0.
REQ-021 LOAD: NUM-th handshake SHALL set coef_loaded=1 and go to STREAM next cycle; coe_ready=0 outside LOAD.
REQ-022 STREAM: smp_ready=1; each smp handshake SHALL register conv_sig_in<=smp_data, conv_sig_vld=1 the following cycle; count 1..frame_len.
REQ-023 conv_last_sig SHALL be 1 exactly with the conv_sig_vld of sample number frame_len; STREAM then goes to DRAIN.
REQ-024 smp_ready SHALL drop in the cycle after the frame_len-th handshake (no extra sample accepted).
REQ-025 Result path: CONV_LAT-deep shift of (conv_sig_vld, conv_last_sig); when delayed valid=1, conv_sig_out registered to res_data with res_valid=1 one cycle later (result at t+CONV_LAT+1, t = conv_sig_vld cycle).
REQ-026 res_last SHALL accompany the result of the last sample; DRAIN goes to DONE the cycle after res_last.
REQ-027 DONE: done=1 for one cycle, then IDLE; back-to-back start accepted the cycle after DONE.
REQ-028 abort in any non-IDLE state SHALL go to IDLE next cycle, clear conv_coes_vld/conv_sig_vld/conv_last_sig and the result shift register, no done pulse.
REQ-029 abort during LOAD SHALL clear coef_loaded; abort in IDLE SHALL have no effect.
REQ-030 Sample counter LEN_W bits; frame_len=2^LEN_W-1 SHALL complete without wrap.

Reset
REQ-031 rst SHALL asynchronously force IDLE, coef_loaded=0, all counters 0, all outputs 0 (busy, done, err, ready, conv_*, res_*).
REQ-032 rst mid-job SHALL drop all in-flight results; first result after reset only from a new job.

Verification
REQ-033 Reset, start coe_reload=1, frame_len=4, coefs 1..8 with gaps in coe_valid -> 8 conv_coes_vld pulses in order, 4 conv_sig_vld, conv_last_sig on 4th, 4 res_valid with res_last on 4th at t+CONV_LAT+1, done pulse.
REQ-034 After reset, start coe_reload=0 -> err pulse, busy stays 0; start frame_len=0 -> err pulse.
REQ-035 Job with coe_reload=0 after a completed load, frame_len=1, smp_valid stalled 5 cycles -> single sample with conv_sig_vld=conv_last_sig=1, one result, done.
REQ-036 abort after 3rd coefficient -> IDLE next cycle, no done, then start coe_reload=0 -> err.
REQ-037 start asserted while busy in STREAM -> ignored; second start the cycle after done -> new job accepted.
REQ-038 rst asserted during DRAIN -> all outputs 0 immediately, no res_valid afterward until a new job.

Source files
------------

// File: rtl/jammer_conv_ctrl.sv
// jammer_conv_ctrl: job sequencer for an external convolver.
// Optionally loads NUM coefficients, streams frame_len samples into the convolver,
// and re-times the convolver results into a result stream.
// Status is reported through busy, plus one-cycle done and err pulses.
module jammer_conv_ctrl #(
  parameter int WIDTH    = 16,
  parameter int NUM      = 8,
  parameter int LEN_W    = 12,
  parameter int CONV_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic                 coe_reload,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     coe_data,
  input  logic                 coe_valid,
  output logic                 coe_ready,
  input  logic [WIDTH-1:0]     smp_data,
  input  logic                 smp_valid,
  output logic                 smp_ready,
  output logic [WIDTH-1:0]     conv_coe,
  output logic                 conv_coes_vld,
  output logic [WIDTH-1:0]     conv_sig_in,
  output logic                 conv_sig_vld,
  output logic                 conv_last_sig,
  input  logic [2*WIDTH-1:0]   conv_sig_out,
  output logic [2*WIDTH-1:0]   res_data,
  output logic                 res_valid,
  output logic                 res_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CNT_W = $clog2(NUM + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]          state;
  logic                coef_loaded;
  logic [CNT_W-1:0]    coe_cnt;
  logic [LEN_W-1:0]    smp_cnt;
  logic [LEN_W-1:0]    len_reg;
  logic [CONV_LAT-1:0] vld_sr;
  logic [CONV_LAT-1:0] last_sr;

  logic coe_fire;
  logic smp_fire;
  logic coe_last;
  logic smp_last;
  logic kill;

  // Ready/status flags are decoded straight from the state register so they
  // are all 0 while rst holds the FSM in IDLE.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign coe_ready = (state == S_LOAD);
  assign smp_ready = (state == S_STREAM);

  assign coe_fire = coe_ready & coe_valid;
  assign smp_fire = smp_ready & smp_valid;
  assign coe_last = (coe_cnt == CNT_W'(NUM - 1));
  // smp_cnt holds the number of samples already taken, so the last sample is
  // recognised one before frame_len; the counter never has to reach frame_len.
  assign smp_last = (smp_cnt == len_reg - LEN_W'(1));
  // abort only acts on a running job
  assign kill     = abort & busy;

  // Job sequencing: start validation, coefficient/sample counting, state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      coef_loaded <= 1'b0;
      coe_cnt     <= '0;
      smp_cnt     <= '0;
      len_reg     <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      if (kill) begin
        state <= S_IDLE;
        // a half-loaded coefficient set cannot be reused
        if (state == S_LOAD) coef_loaded <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (frame_len == '0 || (!coe_reload && !coef_loaded)) begin
                err <= 1'b1;
              end else begin
                len_reg <= frame_len;
                coe_cnt <= '0;
                smp_cnt <= '0;
                state   <= coe_reload ? S_LOAD : S_STREAM;
              end
            end
          end
          S_LOAD: begin
            if (coe_fire) begin
              if (coe_last) begin
                coef_loaded <= 1'b1;
                state       <= S_STREAM;
              end else begin
                coe_cnt <= coe_cnt + CNT_W'(1);
              end
            end
          end
          S_STREAM: begin
            if (smp_fire) begin
              if (smp_last) state <= S_DRAIN;
              else          smp_cnt <= smp_cnt + LEN_W'(1);
            end
          end
          S_DRAIN: begin
            if (res_last) state <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Register accepted coefficients and samples towards the convolver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_coe      <= '0;
      conv_coes_vld <= 1'b0;
      conv_sig_in   <= '0;
      conv_sig_vld  <= 1'b0;
      conv_last_sig <= 1'b0;
    end else if (kill) begin
      conv_coes_vld <= 1'b0;
      conv_sig_vld  <= 1'b0;
      conv_last_sig <= 1'b0;
    end else begin
      conv_coes_vld <= coe_fire;
      conv_sig_vld  <= smp_fire;
      conv_last_sig <= smp_fire & smp_last;
      if (coe_fire) conv_coe    <= coe_data;
      if (smp_fire) conv_sig_in <= smp_data;
    end
  end

  // Delay (valid, last) by the convolver latency to know when conv_sig_out is good.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else if (kill) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= conv_sig_vld;
      last_sr[0] <= conv_last_sig;
      for (int i = 1; i < CONV_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  // Capture the convolver output into the result stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data  <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
    end else if (kill) begin
      res_valid <= 1'b0;
      res_last  <= 1'b0;
    end else begin
      res_valid <= vld_sr[CONV_LAT-1];
      res_last  <= vld_sr[CONV_LAT-1] & last_sr[CONV_LAT-1];
      if (vld_sr[CONV_LAT-1]) res_data <= conv_sig_out;
    end
  end

endmodule

// File: tb/tb_jammer_conv_ctrl.sv
// Self-checking bench for jammer_conv_ctrl: table of jobs plus hand-written
// abort / busy-start / max-length / reset-in-drain sequences, with scoreboard
// queues for coefficients, samples and results.
module tb_jammer_conv_ctrl;
  localparam int WIDTH    = 16;
  localparam int NUM      = 8;
  localparam int LEN_W    = 12;
  localparam int CONV_LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [LEN_W-1:0]     frame_len;
  logic                 coe_reload;
  logic                 abort;
  logic [WIDTH-1:0]     coe_data;
  logic                 coe_valid;
  logic                 coe_ready;
  logic [WIDTH-1:0]     smp_data;
  logic                 smp_valid;
  logic                 smp_ready;
  logic [WIDTH-1:0]     conv_coe;
  logic                 conv_coes_vld;
  logic [WIDTH-1:0]     conv_sig_in;
  logic                 conv_sig_vld;
  logic                 conv_last_sig;
  logic [2*WIDTH-1:0]   conv_sig_out;
  logic [2*WIDTH-1:0]   res_data;
  logic                 res_valid;
  logic                 res_last;
  logic                 busy;
  logic                 done;
  logic                 err;

  jammer_conv_ctrl #(.WIDTH(WIDTH), .NUM(NUM), .LEN_W(LEN_W), .CONV_LAT(CONV_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .coe_reload(coe_reload),
    .abort(abort), .coe_data(coe_data), .coe_valid(coe_valid), .coe_ready(coe_ready),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .conv_coe(conv_coe), .conv_coes_vld(conv_coes_vld), .conv_sig_in(conv_sig_in),
    .conv_sig_vld(conv_sig_vld), .conv_last_sig(conv_last_sig), .conv_sig_out(conv_sig_out),
    .res_data(res_data), .res_valid(res_valid), .res_last(res_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             reload;
    logic [LEN_W-1:0] len;
    int               stall;
    logic             exp_err;
  } job_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } sig_t;

  typedef struct {
    logic [2*WIDTH-1:0] data;
    logic               last;
  } res_t;

  logic [WIDTH-1:0] coe_q[$];
  sig_t             sig_q[$];
  res_t             res_q[$];
  int               lat_q[$];

  int n_vec  = 0;
  int n_bad  = 0;
  int cyc    = 0;
  int res_cnt = 0;

  sig_t mon_s;
  res_t mon_r;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Convolver stand-in: CONV_LAT-cycle pipeline producing {x, x ^ A5A5}.
  logic [WIDTH-1:0] pipe [CONV_LAT];
  always @(posedge clk) begin
    pipe[0] <= conv_sig_in;
    for (int i = 1; i < CONV_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign conv_sig_out = {pipe[CONV_LAT-1], pipe[CONV_LAT-1] ^ 16'hA5A5};

  function automatic logic [2*WIDTH-1:0] conv_model(logic [WIDTH-1:0] s);
    return {s, s ^ 16'hA5A5};
  endfunction

  always @(posedge clk) cyc++;

  // Output monitor: compares DUT outputs against the scoreboard on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (conv_coes_vld) begin
        if (coe_q.size() == 0) flag("unexpected conv_coes_vld");
        else check("conv_coe", conv_coe, coe_q.pop_front());
      end
      if (conv_sig_vld) begin
        if (sig_q.size() == 0) flag("unexpected conv_sig_vld");
        else begin
          mon_s = sig_q.pop_front();
          check("conv_sig_in", conv_sig_in, mon_s.data);
          check("conv_last_sig", conv_last_sig, mon_s.last);
        end
        lat_q.push_back(cyc + CONV_LAT + 1);
      end else if (conv_last_sig) begin
        flag("conv_last_sig without conv_sig_vld");
      end
      if (res_valid) begin
        res_cnt++;
        if (res_q.size() == 0 || lat_q.size() == 0) flag("unexpected res_valid");
        else begin
          mon_r = res_q.pop_front();
          check("res_data", res_data, mon_r.data);
          check("res_last", res_last, mon_r.last);
          check("res_latency_cycle", cyc, lat_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [LEN_W-1:0] len, logic reload);
    start      = 1'b1;
    frame_len  = len;
    coe_reload = reload;
    tick();
    start = 1'b0;
  endtask

  task automatic send_coefs(int n, bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) begin
        coe_valid = 1'b0;
        tick();
        tick();
      end
      coe_data  = WIDTH'(i + 1);
      coe_valid = 1'b1;
      for (int w = 0; w < 50 && !coe_ready; w++) tick();
      if (!coe_ready) begin
        flag("coe_ready timeout");
        coe_valid = 1'b0;
        return;
      end
      coe_q.push_back(coe_data);
      tick();
    end
    coe_valid = 1'b0;
  endtask

  task automatic send_samples(int n, int stall, bit busy_start);
    smp_valid = 1'b0;
    repeat (stall) tick();
    for (int i = 0; i < n; i++) begin
      smp_data  = WIDTH'($urandom);
      smp_valid = 1'b1;
      for (int w = 0; w < 50 && !smp_ready; w++) tick();
      if (!smp_ready) begin
        flag("smp_ready timeout");
        smp_valid = 1'b0;
        return;
      end
      sig_q.push_back('{data: smp_data, last: (i == n - 1)});
      res_q.push_back('{data: conv_model(smp_data), last: (i == n - 1)});
      if (busy_start && i == 2) begin
        start      = 1'b1;
        frame_len  = 12'd1;
        coe_reload = 1'b0;
      end
      tick();
      start = 1'b0;
    end
    check("smp_ready after last sample", smp_ready, 0);
    smp_valid = 1'b0;
  endtask

  task automatic wait_done(int len);
    for (int w = 0; w < 100 && !done; w++) tick();
    check("done pulse", done, 1);
    check("busy in DONE", busy, 1);
    tick();
    check("done one cycle", done, 0);
    check("busy back to idle", busy, 0);
    check("result count", res_cnt, len);
    check("result queue drained", res_q.size(), 0);
  endtask

  task automatic run_job(job_t j, bit busy_start);
    res_cnt = 0;
    do_start(j.len, j.reload);
    if (j.exp_err) begin
      check("err pulse", err, 1);
      check("busy after bad start", busy, 0);
      tick();
      check("err one cycle", err, 0);
    end else begin
      check("no err on good start", err, 0);
      check("busy after start", busy, 1);
      check("coe_ready after start", coe_ready, j.reload);
      if (j.reload) send_coefs(NUM, 1'b1);
      check("smp_ready in STREAM", smp_ready, 1);
      check("coe_ready in STREAM", coe_ready, 0);
      send_samples(int'(j.len), j.stall, busy_start);
      wait_done(int'(j.len));
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
    check({tag, " coe_ready"}, coe_ready, 0);
    check({tag, " smp_ready"}, smp_ready, 0);
    check({tag, " conv_coes_vld"}, conv_coes_vld, 0);
    check({tag, " conv_sig_vld"}, conv_sig_vld, 0);
    check({tag, " conv_last_sig"}, conv_last_sig, 0);
    check({tag, " res_valid"}, res_valid, 0);
    check({tag, " res_last"}, res_last, 0);
    check({tag, " res_data"}, res_data, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  job_t jobs [7];

  initial begin
    jobs[0] = '{reload: 1'b0, len: 12'd4, stall: 0, exp_err: 1'b1};
    jobs[1] = '{reload: 1'b1, len: 12'd0, stall: 0, exp_err: 1'b1};
    jobs[2] = '{reload: 1'b1, len: 12'd4, stall: 0, exp_err: 1'b0};
    jobs[3] = '{reload: 1'b0, len: 12'd1, stall: 5, exp_err: 1'b0};
    jobs[4] = '{reload: 1'b0, len: 12'd7, stall: 1, exp_err: 1'b0};
    jobs[5] = '{reload: 1'b1, len: 12'd3, stall: 0, exp_err: 1'b0};
    jobs[6] = '{reload: 1'b0, len: 12'd0, stall: 0, exp_err: 1'b1};

    rst = 1'b1; start = 1'b0; frame_len = '0; coe_reload = 1'b0; abort = 1'b0;
    coe_data = '0; coe_valid = 1'b0; smp_data = '0; smp_valid = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_job(jobs[i], 1'b0);

    // abort during LOAD after the 3rd coefficient, then a no-reload start must fail
    res_cnt = 0;
    do_start(12'd4, 1'b1);
    send_coefs(3, 1'b0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort conv_coes_vld", conv_coes_vld, 0);
    check("abort done", done, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("no done after abort", done, 0);
    end
    check("abort coef queue", coe_q.size(), 0);
    run_job('{reload: 1'b0, len: 12'd2, stall: 0, exp_err: 1'b1}, 1'b0);

    // start while streaming is ignored; back-to-back start after DONE is taken
    run_job('{reload: 1'b1, len: 12'd5, stall: 0, exp_err: 1'b0}, 1'b1);
    run_job('{reload: 1'b0, len: 12'd3, stall: 0, exp_err: 1'b0}, 1'b0);

    // longest frame the counter allows
    run_job('{reload: 1'b0, len: 12'd4095, stall: 0, exp_err: 1'b0}, 1'b0);

    // reset while results are still in flight
    res_cnt = 0;
    do_start(12'd3, 1'b0);
    send_samples(3, 0, 1'b0);
    rst = 1'b1;
    #1;
    check_all_zero("rst in DRAIN");
    tick();
    rst = 1'b0;
    sig_q.delete();
    res_q.delete();
    lat_q.delete();
    coe_q.delete();
    res_cnt = 0;
    repeat (10) tick();
    check("no results after reset", res_cnt, 0);
    run_job('{reload: 1'b0, len: 12'd2, stall: 0, exp_err: 1'b1}, 1'b0);
    run_job('{reload: 1'b1, len: 12'd2, stall: 0, exp_err: 1'b0}, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
